// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encodings, owner
// encodings and the grant selection helper.
package mem_port_arbiter_pkg;

  localparam int ARB_STATE_LEN = 2;

  typedef enum logic [ARB_STATE_LEN-1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWN_IF = 1'b0,
    ARB_OWN_D  = 1'b1
  } arb_owner_t;

  // Chooses the port to grant. A lone request always wins. On contention,
  // round-robin hands the port to whoever did not own it last; fixed
  // priority always favours the data side.
  function automatic arb_owner_t pick_owner(input logic if_req,
                                            input logic d_req,
                                            input arb_owner_t last_owner,
                                            input logic rr_en);
    arb_owner_t owner;
    if (if_req && d_req) begin
      if (rr_en) owner = (last_owner == ARB_OWN_IF) ? ARB_OWN_D : ARB_OWN_IF;
      else       owner = ARB_OWN_D;
    end else if (d_req) begin
      owner = ARB_OWN_D;
    end else begin
      owner = ARB_OWN_IF;
    end
    return owner;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter that times the memory access phase. It stops at
// zero and flags when it gets there.
module arb_wait_counter #(
  parameter int CNT_LEN = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [CNT_LEN-1:0] value,
  input  logic               dec,
  output logic               zero
);

  logic [CNT_LEN-1:0] count;

  // Load takes precedence; otherwise count down without wrapping below zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data
// load/store. Each requester holds a level req until it sees a one-cycle
// done pulse. Define ARB_ROUND_ROBIN_EN to replace fixed data-first priority
// with alternating grants on contention.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_LEN    = 32,
  parameter int DATA_LEN    = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_LEN-1:0] if_addr,
  output logic                if_done,
  output logic [DATA_LEN-1:0] if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_LEN-1:0] d_addr,
  input  logic [DATA_LEN-1:0] d_wdata,
  output logic                d_done,
  output logic [DATA_LEN-1:0] d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  input  logic [DATA_LEN-1:0] mem_rdata,
  output logic                busy
);

  localparam int CNT_LEN = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_LEN-1:0] CNT_LOAD = CNT_LEN'(WAIT_CYCLES - 1);

  arb_state_t          state;
  arb_owner_t          owner;
  arb_owner_t          grant_owner;
  logic                lat_we;
  logic [ADDR_LEN-1:0] lat_addr;
  logic [DATA_LEN-1:0] lat_wdata;
  logic [DATA_LEN-1:0] if_rdata_q;
  logic [DATA_LEN-1:0] d_rdata_q;
  logic                start;
  logic                cnt_dec;
  logic                cnt_zero;

  assign start   = (state == ARB_IDLE) && (if_req || d_req);
  assign cnt_dec = (state == ARB_ACCESS) && !cnt_zero;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last_owner;

  // Remember who was granted last so contention alternates between ports.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner <= ARB_OWN_IF;
    end else if (start) begin
      last_owner <= grant_owner;
    end
  end

  assign grant_owner = pick_owner(if_req, d_req, last_owner, 1'b1);
`else
  assign grant_owner = pick_owner(if_req, d_req, ARB_OWN_IF, 1'b0);
`endif

  arb_wait_counter #(
    .CNT_LEN(CNT_LEN)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (start),
    .value(CNT_LOAD),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  // Transfer sequencer: latch the winner's request at grant, wait out the
  // memory latency, capture read data on the way out, then pulse done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      owner      <= ARB_OWN_IF;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (start) begin
            state <= ARB_ACCESS;
            owner <= grant_owner;
            if (grant_owner == ARB_OWN_D) begin
              lat_we    <= d_we;
              lat_addr  <= d_addr;
              lat_wdata <= d_wdata;
            end else begin
              lat_we    <= 1'b0;
              lat_addr  <= if_addr;
              lat_wdata <= '0;
            end
          end
        end
        ARB_ACCESS: begin
          if (cnt_zero) begin
            state <= ARB_DONE;
            if (!lat_we) begin
              if (owner == ARB_OWN_D) d_rdata_q  <= mem_rdata;
              else                    if_rdata_q <= mem_rdata;
            end
          end
        end
        ARB_DONE: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign mem_en    = (state == ARB_ACCESS);
  assign mem_we    = mem_en && lat_we;
  assign mem_addr  = mem_en ? lat_addr : '0;
  assign mem_wdata = mem_en ? lat_wdata : '0;
  assign if_done   = (state == ARB_DONE) && (owner == ARB_OWN_IF);
  assign d_done    = (state == ARB_DONE) && (owner == ARB_OWN_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with WAIT_CYCLES=2 and
// one with WAIT_CYCLES=1. Expected grant order adapts to ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  logic        w1_if_req;
  logic [31:0] w1_if_addr;
  logic        w1_if_done;
  logic [31:0] w1_if_rdata;
  logic        w1_d_req;
  logic        w1_d_we;
  logic [31:0] w1_d_addr;
  logic [31:0] w1_d_wdata;
  logic        w1_d_done;
  logic [31:0] w1_d_rdata;
  logic        w1_mem_en;
  logic        w1_mem_we;
  logic [31:0] w1_mem_addr;
  logic [31:0] w1_mem_wdata;
  logic        w1_busy;

  int assert_count = 0;
  int fail_count   = 0;
  logic exp_d;

  mem_port_arbiter #(.ADDR_LEN(32), .DATA_LEN(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_LEN(32), .DATA_LEN(32), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .if_req(w1_if_req), .if_addr(w1_if_addr), .if_done(w1_if_done),
    .if_rdata(w1_if_rdata),
    .d_req(w1_d_req), .d_we(w1_d_we), .d_addr(w1_d_addr), .d_wdata(w1_d_wdata),
    .d_done(w1_d_done), .d_rdata(w1_d_rdata),
    .mem_en(w1_mem_en), .mem_we(w1_mem_we), .mem_addr(w1_mem_addr),
    .mem_wdata(w1_mem_wdata), .mem_rdata(mem_rdata), .busy(w1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clock edges and land just after the last one.
  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
    w1_if_req = 1'b0; w1_if_addr = '0;
    w1_d_req = 1'b0; w1_d_we = 1'b0; w1_d_addr = '0; w1_d_wdata = '0;

    $display("[TB] reset state");
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_if_done", if_done, 0);
    checkOutput("rst_d_done", d_done, 0);
    checkOutput("rst_if_rdata", if_rdata, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);
    stepCycles(2);
    rst = 1'b1;

    $display("[TB] store");
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'hBAD0_BAD0;
    stepCycles(1);
    checkOutput("st_c1_mem_en", mem_en, 1);
    checkOutput("st_c1_mem_we", mem_we, 1);
    checkOutput("st_c1_mem_addr", mem_addr, 32'h10);
    checkOutput("st_c1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    d_addr = 32'h99; d_wdata = 32'h0;
    stepCycles(1);
    checkOutput("st_c2_mem_we", mem_we, 1);
    checkOutput("st_c2_mem_addr", mem_addr, 32'h10);
    checkOutput("st_c2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    checkOutput("st_c2_d_done", d_done, 0);
    stepCycles(1);
    checkOutput("st_c3_d_done", d_done, 1);
    checkOutput("st_c3_mem_en", mem_en, 0);
    checkOutput("st_c3_d_rdata", d_rdata, 0);
    checkOutput("st_c3_if_rdata", if_rdata, 0);
    d_req = 1'b0; d_we = 1'b0;
    stepCycles(1);
    checkOutput("st_c4_d_done", d_done, 0);
    checkOutput("st_c4_busy", busy, 0);

    $display("[TB] fetch");
    if_req = 1'b1; if_addr = 32'h0000_0040; mem_rdata = 32'h2002_0005;
    stepCycles(1);
    checkOutput("if_c1_mem_en", mem_en, 1);
    checkOutput("if_c1_mem_we", mem_we, 0);
    checkOutput("if_c1_mem_addr", mem_addr, 32'h40);
    checkOutput("if_c1_busy", busy, 1);
    stepCycles(1);
    checkOutput("if_c2_mem_en", mem_en, 1);
    checkOutput("if_c2_if_done", if_done, 0);
    stepCycles(1);
    checkOutput("if_c3_if_done", if_done, 1);
    checkOutput("if_c3_d_done", d_done, 0);
    checkOutput("if_c3_mem_en", mem_en, 0);
    checkOutput("if_c3_if_rdata", if_rdata, 32'h2002_0005);
    checkOutput("if_c3_d_rdata", d_rdata, 0);
    if_req = 1'b0;
    stepCycles(1);
    checkOutput("if_c4_if_done", if_done, 0);

    $display("[TB] simultaneous requests");
    if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    mem_rdata = 32'h1111_1111;
    stepCycles(1);
    checkOutput("sim_c1_mem_addr", mem_addr, 32'h20);
    stepCycles(2);
    checkOutput("sim_c3_d_done", d_done, 1);
    checkOutput("sim_c3_if_done", if_done, 0);
    checkOutput("sim_c3_d_rdata", d_rdata, 32'h1111_1111);
    d_req = 1'b0; mem_rdata = 32'h2222_2222;
    stepCycles(1);
    checkOutput("sim_c4_busy", busy, 0);
    stepCycles(1);
    checkOutput("sim_c5_mem_addr", mem_addr, 32'h44);
    stepCycles(1);
    checkOutput("sim_c6_if_done", if_done, 0);
    stepCycles(1);
    checkOutput("sim_c7_if_done", if_done, 1);
    checkOutput("sim_c7_if_rdata", if_rdata, 32'h2222_2222);
    checkOutput("sim_c7_d_rdata", d_rdata, 32'h1111_1111);
    if_req = 1'b0;
    stepCycles(1);

    $display("[TB] held contention, four transfers");
    if_req = 1'b1; if_addr = 32'h48;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (i % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      stepCycles(3);
      checkOutput($sformatf("hold%0d_d_done", i), d_done, exp_d);
      checkOutput($sformatf("hold%0d_if_done", i), if_done, !exp_d);
      if (i == 3) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      stepCycles(1);
      checkOutput($sformatf("hold%0d_idle", i), busy, 0);
    end

    $display("[TB] reset during store");
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hCAFE_F00D;
    stepCycles(1);
    checkOutput("rs_c1_mem_we", mem_we, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rs_mem_en", mem_en, 0);
    checkOutput("rs_mem_we", mem_we, 0);
    checkOutput("rs_mem_addr", mem_addr, 0);
    checkOutput("rs_mem_wdata", mem_wdata, 0);
    checkOutput("rs_busy", busy, 0);
    checkOutput("rs_d_rdata", d_rdata, 0);
    checkOutput("rs_if_rdata", if_rdata, 0);
    d_req = 1'b0; d_we = 1'b0;
    stepCycles(1);
    checkOutput("rs_d_done", d_done, 0);
    rst = 1'b1;
    stepCycles(1);
    checkOutput("rs_idle", busy, 0);
    d_req = 1'b1; d_addr = 32'h34; mem_rdata = 32'h0BAD_CAFE;
    stepCycles(1);
    checkOutput("rs_new_mem_addr", mem_addr, 32'h34);
    checkOutput("rs_new_mem_we", mem_we, 0);
    stepCycles(2);
    checkOutput("rs_new_d_done", d_done, 1);
    checkOutput("rs_new_d_rdata", d_rdata, 32'h0BAD_CAFE);
    d_req = 1'b0;
    stepCycles(1);

    $display("[TB] single wait cycle");
    w1_if_req = 1'b1; w1_if_addr = 32'h80; mem_rdata = 32'hAAAA_5555;
    stepCycles(1);
    checkOutput("w1_if_c1_mem_en", w1_mem_en, 1);
    checkOutput("w1_if_c1_mem_addr", w1_mem_addr, 32'h80);
    stepCycles(1);
    checkOutput("w1_if_c2_if_done", w1_if_done, 1);
    checkOutput("w1_if_c2_if_rdata", w1_if_rdata, 32'hAAAA_5555);
    w1_if_req = 1'b0;
    stepCycles(1);
    w1_d_req = 1'b1; w1_d_we = 1'b0; w1_d_addr = 32'h1C; mem_rdata = 32'h1234_5678;
    stepCycles(1);
    checkOutput("w1_ld_c1_mem_en", w1_mem_en, 1);
    checkOutput("w1_ld_c1_mem_addr", w1_mem_addr, 32'h1C);
    stepCycles(1);
    checkOutput("w1_ld_c2_mem_en", w1_mem_en, 0);
    checkOutput("w1_ld_c2_d_done", w1_d_done, 1);
    checkOutput("w1_ld_c2_d_rdata", w1_d_rdata, 32'h1234_5678);
    checkOutput("w1_ld_c2_if_rdata", w1_if_rdata, 32'hAAAA_5555);
    w1_d_req = 1'b0;
    stepCycles(1);
    checkOutput("w1_ld_c3_d_done", w1_d_done, 0);
    checkOutput("w1_ld_c3_busy", w1_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
